// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM interface: RAM handshake states,
// arbiter states and the machine word type.
// Optional build macro: ARB_FAIR_EN (round-robin arbitration).
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFETCH = 2'd1,
      DREAD  = 2'd2,
      DWRITE = 2'd3
   } arb_state_t;

   // Encoding of the last-granted pointer used by round-robin arbitration
   localparam logic PTR_ICACHE = 1'b0;
   localparam logic PTR_DCACHE = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant selection between icache and dcache requests.
// Within the dcache a write always beats a read.
// Optional build macro: ARB_FAIR_EN. When defined, simultaneous icache and
// dcache requests alternate based on the parent's last-granted pointer;
// otherwise the dcache always wins.
module mem_arb_grant
   import cpu_types_pkg::*;
(
   input  logic       i_iRen,
   input  logic       i_dRen,
   input  logic       i_dWen,
`ifdef ARB_FAIR_EN
   input  logic       i_lastGrant,
`endif
   output logic [1:0] o_grant
);

   logic       w_dWant;
   arb_state_t w_dState;
   arb_state_t w_grant;

   assign w_dWant  = i_dRen | i_dWen;
   assign o_grant  = w_grant;

   // Pick the access state for whichever requester is granted this cycle
   always_comb begin
      w_dState = i_dWen ? DWRITE : DREAD;
      w_grant  = IDLE;
      if (w_dWant && i_iRen) begin
`ifdef ARB_FAIR_EN
         w_grant = (i_lastGrant == PTR_DCACHE) ? IFETCH : w_dState;
`else
         w_grant = w_dState;
`endif
      end else if (w_dWant) begin
         w_grant = w_dState;
      end else if (i_iRen) begin
         w_grant = IFETCH;
      end
   end

endmodule

// File: rtl/mem_arbiter_responder.sv
// Memory-controller end of the caches interface. Arbitrates between one
// icache and one dcache requester and runs one transaction at a time on a
// variable-latency RAM port, with timeout and sticky error reporting.
// Optional build macro: ARB_FAIR_EN (round-robin between icache and dcache).
module mem_arbiter_responder
   import cpu_types_pkg::*;
#(
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 64
)
(
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              merr
);

   localparam int            CW         = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

   arb_state_t        r_state;
   arb_state_t        w_nextState;
   arb_state_t        w_grant;
   logic [1:0]        w_grantRaw;
   ramstate_t         w_ramState;
   logic [WORD_W-1:0] r_addr;
   logic [WORD_W-1:0] r_store;
   logic [CW-1:0]     r_count;
   logic [WORD_W-1:0] r_iload;
   logic [WORD_W-1:0] r_dload;
   logic              r_merr;
   logic              w_inAccess;
   logic              w_abort;
   logic              w_done;
   logic [WORD_W-1:0] w_readData;
`ifdef ARB_FAIR_EN
   logic              r_lastGrant;
`endif

   mem_arb_grant uGrant (
      .i_iRen      (iREN),
      .i_dRen      (dREN),
      .i_dWen      (dWEN),
`ifdef ARB_FAIR_EN
      .i_lastGrant (r_lastGrant),
`endif
      .o_grant     (w_grantRaw)
   );

   assign w_grant    = arb_state_t'(w_grantRaw);
   assign w_ramState = ramstate_t'(ramstate);
   assign w_inAccess = (r_state != IDLE);
   // The final allowed cycle aborts unless the RAM answers in it
   assign w_abort    = w_inAccess && (w_ramState != ACCESS) &&
                       ((w_ramState == ERROR) || (r_count == LAST_COUNT));
   assign w_done     = w_inAccess && ((w_ramState == ACCESS) || w_abort);
   assign w_readData = w_abort ? '0 : ramload;
   assign ramaddr    = r_addr;
   assign ramstore   = r_store;
   assign merr       = r_merr;

   // State register
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Next state: IDLE takes the grant, access states return on completion
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    w_nextState = w_grant;
         default: if (w_done) w_nextState = IDLE;
      endcase
   end

   // Outputs: RAM strobes per access state, wait pulse and load on completion
   always_comb begin
      iwait  = 1'b1;
      dwait  = 1'b1;
      iload  = r_iload;
      dload  = r_dload;
      ramREN = 1'b0;
      ramWEN = 1'b0;
      case (r_state)
         IFETCH: begin
            ramREN = 1'b1;
            if (w_done) begin
               iwait = 1'b0;
               iload = w_readData;
            end
         end
         DREAD: begin
            ramREN = 1'b1;
            if (w_done) begin
               dwait = 1'b0;
               dload = w_readData;
            end
         end
         DWRITE: begin
            ramWEN = 1'b1;
            if (w_done) dwait = 1'b0;
         end
         default: ;
      endcase
   end

   // Latch the granted address and write data so requester changes are ignored
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_addr  <= '0;
         r_store <= '0;
      end else if (r_state == IDLE && w_grant != IDLE) begin
         r_addr <= (w_grant == IFETCH) ? iaddr : daddr;
         if (w_grant == DWRITE) r_store <= dstore;
      end
   end

   // Access-cycle counter: cleared while idle, counts RAM cycles without an answer
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST)                    r_count <= '0;
      else if (r_state == IDLE)     r_count <= '0;
      else if (!w_done)             r_count <= r_count + CW'(1);
   end

   // Hold the last returned words so the load outputs stay stable between pulses
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_iload <= '0;
         r_dload <= '0;
      end else if (w_done) begin
         if (r_state == IFETCH) r_iload <= w_readData;
         if (r_state == DREAD)  r_dload <= w_readData;
      end
   end

   // Sticky error flag set by any RAM error or timeout abort
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST)        r_merr <= 1'b0;
      else if (w_abort) r_merr <= 1'b1;
   end

`ifdef ARB_FAIR_EN
   // Remember who was granted last so the other side wins the next tie
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST)
         r_lastGrant <= PTR_ICACHE;
      else if (r_state == IDLE && w_grant != IDLE)
         r_lastGrant <= (w_grant == IFETCH) ? PTR_ICACHE : PTR_DCACHE;
   end
`endif

endmodule
